// File: rtl/ps2_key_event_fifo_if.sv
// Handshake bundle between the PS/2 byte source, the key-event FIFO and its consumer.
// master = byte source / consumer side, slave = ps2_key_event_fifo.
interface ps2_key_event_fifo_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;

    modport master (
        output rx_data, rx_valid, evt_ready,
        input  evt_valid, evt_code, evt_ext, evt_break
    );

    modport slave (
        input  rx_data, rx_valid, evt_ready,
        output evt_valid, evt_code, evt_ext, evt_break
    );
endinterface

// File: rtl/ps2_key_event_fifo.sv
// PS/2 set-2 byte decoder (E0/F0 prefixes) feeding a DEPTH-entry key-event FIFO; LEDs mirror last make.
// Define PS2_BREAK_EVENT_EN to push break (release) events into the FIFO as well.
module ps2_key_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LED_W = 8,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    ps2_key_event_fifo_if.slave  bus,
    output logic [CW-1:0]        count,
    output logic                 overflow,
    output logic [LED_W-1:0]     leds
);

`ifdef PS2_BREAK_EVENT_EN
    localparam bit BreakEn = 1'b1;
`else
    localparam bit BreakEn = 1'b0;
`endif

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StE0, StF0, StE0F0} state_e;

    state_e state_q, state_d;

    logic is_junk, is_e0, is_f0;
    logic emit, emit_ext, emit_brk;

    assign is_junk = (bus.rx_data == 8'h00) || (bus.rx_data == 8'hFF);
    assign is_e0   = (bus.rx_data == 8'hE0);
    assign is_f0   = (bus.rx_data == 8'hF0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.rx_valid) begin
            if (is_junk) begin
                state_d = StIdle;
            end else if (is_e0) begin
                state_d = StE0;
            end else if (is_f0) begin
                // A break prefix keeps the extended flag if E0 was already seen.
                state_d = (state_q == StE0 || state_q == StE0F0) ? StE0F0 : StF0;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_comb begin
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        if (bus.rx_valid && !is_junk && !is_e0 && !is_f0) begin
            emit = 1'b1;
            case (state_q)
                StIdle: ;
                StE0:   emit_ext = 1'b1;
                StF0:   emit_brk = 1'b1;
                StE0F0: begin
                    emit_ext = 1'b1;
                    emit_brk = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Entry layout: {ext, brk, code}.
    logic [9:0]       mem_q [DEPTH];
    logic [9:0]       mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [LED_W-1:0] leds_q, leds_d;

    logic empty, full, pop, push_req, do_push;
    logic [9:0] head;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign pop      = !empty && bus.evt_ready;
    assign push_req = emit && (BreakEn || !emit_brk);
    assign do_push  = push_req && (!full || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        leds_d     = leds_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = {emit_ext, emit_brk, bus.rx_data};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end
        // Make codes update the LEDs even when the FIFO drops the event.
        if (emit && !emit_brk) begin
            leds_d = LED_W'(bus.rx_data);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            leds_q     <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            leds_q     <= leds_d;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.evt_valid = !empty;
    assign bus.evt_code  = empty ? 8'h00 : head[7:0];
    assign bus.evt_ext   = !empty && head[9];
    assign bus.evt_break = !empty && head[8] && BreakEn;

    assign count    = count_q;
    assign overflow = overflow_q;
    assign leds     = leds_q;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Scoreboard bench for ps2_key_event_fifo: directed bytes push expected events, a monitor checks pops.
module tb_ps2_key_event_fifo;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] count;
    logic       overflow;
    logic [7:0] leds;

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_q[$];

    ps2_key_event_fifo_if bus ();

    ps2_key_event_fifo #(.DEPTH(8), .LED_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus.slave),
        .count    (count),
        .overflow (overflow),
        .leds     (leds)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    // Monitor: a handshake seen mid-cycle pops at the next rising edge.
    always @(negedge clock) begin
        if (!reset && bus.evt_valid && bus.evt_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {22'd0, bus.evt_ext, bus.evt_break, bus.evt_code},
                      32'hFFFF_FFFF);
            end else begin
                check("event", {22'd0, bus.evt_ext, bus.evt_break, bus.evt_code},
                      {22'd0, exp_q.pop_front()});
            end
        end
    end

    // Drive one byte for one cycle; called at posedge+1, returns at posedge+1.
    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.rx_data   = 8'h1C;
        bus.rx_valid  = 1'b1;
        bus.evt_ready = 1'b0;

        // 1: reset with a byte pending
        idle(2);
        check("rst_valid", {31'd0, bus.evt_valid}, 32'd0);
        check("rst_code", {24'd0, bus.evt_code}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_leds", {24'd0, leds}, 32'd0);
        bus.rx_valid = 1'b0;
        reset = 1'b0;
        idle(5);
        check("idle_valid", {31'd0, bus.evt_valid}, 32'd0);
        check("idle_count", {28'd0, count}, 32'd0);

        // 2: simple make code, one-cycle latency
        bus.evt_ready = 1'b1;
        exp_q.push_back({2'b00, 8'h1C});
        send(8'h1C);
        check("make_valid", {31'd0, bus.evt_valid}, 32'd1);
        check("make_code", {24'd0, bus.evt_code}, 32'h1C);
        check("make_leds", {24'd0, leds}, 32'h1C);
        idle(1);
        check("make_popped", {31'd0, bus.evt_valid}, 32'd0);

        // 3: extended break E0 F0 75
`ifdef PS2_BREAK_EVENT_EN
        exp_q.push_back({2'b11, 8'h75});
`endif
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        idle(2);
        check("brk_leds", {24'd0, leds}, 32'h1C);
        check("brk_count", {28'd0, count}, 32'd0);
        check("brk_ovf", {31'd0, overflow}, 32'd0);

        // 4: overflow with consumer stalled
        bus.evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back({2'b00, 8'h10 + 8'(i)});
            send(8'h10 + 8'(i));
        end
        check("ovf_count", {28'd0, count}, 32'd8);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_head", {24'd0, bus.evt_code}, 32'h10);
        check("ovf_leds", {24'd0, leds}, 32'h18);
        bus.evt_ready = 1'b1;
        idle(10);
        check("drain_count", {28'd0, count}, 32'd0);
        check("drain_ovf", {31'd0, overflow}, 32'd1);

        // 5: simultaneous push/pop on full
        pulse_reset();
        bus.evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({2'b00, 8'h30 + 8'(i)});
            send(8'h30 + 8'(i));
        end
        check("full_count", {28'd0, count}, 32'd8);
        bus.evt_ready = 1'b1;
        exp_q.push_back({2'b00, 8'h2A});
        send(8'h2A);
        check("pp_count", {28'd0, count}, 32'd8);
        check("pp_ovf", {31'd0, overflow}, 32'd0);
        idle(10);
        check("pp_drain", {28'd0, count}, 32'd0);

        // 6: reset discards prefix; 0x00 clears prefix
        send(8'hE0);
        pulse_reset();
        bus.evt_ready = 1'b1;
        exp_q.push_back({2'b00, 8'h1C});
        send(8'h1C);
        idle(2);
        send(8'hF0);
        send(8'h00);
        exp_q.push_back({2'b00, 8'h1C});
        send(8'h1C);
        idle(3);
        check("junk_leds", {24'd0, leds}, 32'h1C);
        check("junk_count", {28'd0, count}, 32'd0);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
